regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 133 +++++++++++++
 tb/tb_regfile_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised two-read/one-write register file with a registered debug port
// and a self-timed clear sequence that zeroes every entry after reset or on request.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_nx1;
  logic [DATA_W-1:0] rd_nx2;
  logic [DATA_W-1:0] dbg_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    unique case (state)
      CLEAR: begin
        if (clr_ptr == '1) begin
          state_nx   = IDLE;
          clr_ptr_nx = '0;
        end else begin
          clr_ptr_nx = clr_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
      default: begin
        state_nx   = CLEAR;
        clr_ptr_nx = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // Host writes only land in IDLE; writes to a hardwired-zero entry are dropped.
  always_comb begin
    wr_ok     = (state == IDLE) && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
      end else if (wr_ok) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Zero-register override is applied last so it wins over forwarding.
  always_comb begin
    rd_nx1 = mem[rd_addr1];
    rd_nx2 = mem[rd_addr2];
    dbg_nx = mem[dbg_addr];
    if ((BYPASS != 0) && wr_ok) begin
      if (wr_addr == rd_addr1) rd_nx1 = wr_data;
      if (wr_addr == rd_addr2) rd_nx2 = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_nx1 = '0;
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_nx2 = '0;
    if ((ZERO_REG != 0) && (dbg_addr == '0)) dbg_nx = '0;
  end

  always_ff @(posedge clock) begin
    if (reset || (state == CLEAR)) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      dbg_data <= '0;
    end else begin
      rd_data1 <= rd_nx1;
      rd_data2 <= rd_nx2;
      dbg_data <= dbg_nx;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a default instance and a no-zero-reg,
// no-bypass instance share stimulus; expectations are queued per driven cycle.
module tb_regfile_param;

  logic        clock;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic        wr_en, clr_req;
  logic [31:0] wr_data;

  logic [31:0] rd_data1_a, rd_data2_a, dbg_data_a;
  logic [31:0] rd_data1_b, rd_data2_b, dbg_data_b;
  logic        busy_a, busy_b;
  logic [191:0] got;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        tag;
    logic [191:0] v;
  } exp_t;

  typedef struct {
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [4:0]   a1, a2, ad;
    logic [191:0] ev;
  } row_t;

  exp_t sbq[$];

  regfile_param dut_a (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_a), .rd_data2(rd_data2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_a)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  assign got = {rd_data1_a, rd_data2_a, dbg_data_a, rd_data1_b, rd_data2_b, dbg_data_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [191:0] pk(input logic [31:0] a1, a2, ad, b1, b2, bd);
    return {a1, a2, ad, b1, b2, bd};
  endfunction

  function automatic exp_t mkexp(input string t, input logic [191:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    return e;
  endfunction

  function automatic row_t row(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] a1, a2, ad, input logic [191:0] ev);
    row_t r;
    r.we = we; r.wa = wa; r.wd = wd;
    r.a1 = a1; r.a2 = a2; r.ad = ad; r.ev = ev;
    return r;
  endfunction

  function automatic logic [31:0] fillv(input int i);
    return 32'h8000_0000 | (32'(i) * 32'h0101_0101);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic cr, input logic [4:0] a1, a2, ad);
    wr_en = we; wr_addr = wa; wr_data = wd; clr_req = cr;
    rd_addr1 = a1; rd_addr2 = a2; dbg_addr = ad;
  endtask

  task automatic test_reset();
    exp_t e;
    int n;
    reset = 1'b1;
    drive(1'b1, 5'd6, 32'h0BAD_0BAD, 1'b1, 5'd1, 5'd2, 5'd3);
    sbq.push_back(mkexp("reset_out", '0));
    step(); step();
    e = sbq.pop_front();
    checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL reset_busy got=%b exp=11", {busy_a, busy_b}); end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (busy_a === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL reset_busy_len got=%0d exp=32", n); end
    checks++;
    if ({busy_a, busy_b} !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b exp=00", {busy_a, busy_b}); end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i), 5'((i + 7) % 32));
      sbq.push_back(mkexp($sformatf("reset_sweep[%0d]", i), '0));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_write_read();
    row_t t[$];
    exp_t e;
    t.push_back(row(1, 5,  32'hDEADBEEF, 5, 0, 5, pk(32'hDEADBEEF, 0, 0, 0, 0, 0)));
    t.push_back(row(0, 0,  32'h0,        5, 5, 5, pk(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                                                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF)));
    t.push_back(row(1, 9,  32'hA5A5A5A5, 9, 5, 9, pk(32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0)));
    t.push_back(row(0, 0,  32'h0,        5, 9, 9, pk(32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5,
                                                     32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5)));
    foreach (t[i]) begin
      drive(t[i].we, t[i].wa, t[i].wd, 1'b0, t[i].a1, t[i].a2, t[i].ad);
      sbq.push_back(mkexp($sformatf("write_read[%0d]", i), t[i].ev));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_bypass();
    row_t t[$];
    exp_t e;
    t.push_back(row(1, 7, 32'h12345678, 7, 9, 7, pk(32'h12345678, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0)));
    t.push_back(row(0, 0, 32'h0,        7, 7, 7, pk(32'h12345678, 32'h12345678, 32'h12345678,
                                                    32'h12345678, 32'h12345678, 32'h12345678)));
    foreach (t[i]) begin
      drive(t[i].we, t[i].wa, t[i].wd, 1'b0, t[i].a1, t[i].a2, t[i].ad);
      sbq.push_back(mkexp($sformatf("bypass[%0d]", i), t[i].ev));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$];
    exp_t e;
    t.push_back(row(1, 10, 32'h11111111, 10, 7, 10, pk(32'h11111111, 32'h12345678, 0, 0, 32'h12345678, 0)));
    t.push_back(row(1, 11, 32'h22222222, 11, 10, 11, pk(32'h22222222, 32'h11111111, 0, 0, 32'h11111111, 0)));
    t.push_back(row(1, 10, 32'h33333333, 10, 11, 10, pk(32'h33333333, 32'h22222222, 32'h11111111,
                                                       32'h11111111, 32'h22222222, 32'h11111111)));
    t.push_back(row(0, 0,  32'h0,        10, 11, 10, pk(32'h33333333, 32'h22222222, 32'h33333333,
                                                       32'h33333333, 32'h22222222, 32'h33333333)));
    foreach (t[i]) begin
      drive(t[i].we, t[i].wa, t[i].wd, 1'b0, t[i].a1, t[i].a2, t[i].ad);
      sbq.push_back(mkexp($sformatf("back_to_back[%0d]", i), t[i].ev));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_zero_reg();
    row_t t[$];
    exp_t e;
    t.push_back(row(1, 0, 32'hFFFFFFFF, 0, 5, 0, pk(0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0)));
    t.push_back(row(0, 0, 32'h0,        0, 0, 0, pk(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)));
    foreach (t[i]) begin
      drive(t[i].we, t[i].wa, t[i].wd, 1'b0, t[i].a1, t[i].a2, t[i].ad);
      sbq.push_back(mkexp($sformatf("zero_reg[%0d]", i), t[i].ev));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int n;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), fillv(i), 1'b0, 5'd0, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd31);
    sbq.push_back(mkexp("clear_start", pk(fillv(3), 0, fillv(31), fillv(3), 32'hFFFFFFFF, fillv(31))));
    step();
    e = sbq.pop_front();
    checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL clear_busy got=%b exp=11", {busy_a, busy_b}); end
    n = 1;
    for (int k = 0; k < 100; k++) begin
      drive(k == 0, 5'd3, 32'hCAFEF00D, k == 1, 5'd3, 5'(k), 5'd3);
      sbq.push_back(mkexp($sformatf("clear_busy_out[%0d]", k), '0));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
      if (busy_a === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL clear_busy_len got=%0d exp=32", n); end
    checks++;
    if ({busy_a, busy_b} !== 2'b00) begin failures++; $display("FAIL clear_idle got=%b exp=00", {busy_a, busy_b}); end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i), 5'((i + 3) % 32));
      sbq.push_back(mkexp($sformatf("clear_sweep[%0d]", i), '0));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_reset_mid_clear();
    row_t t[$];
    exp_t e;
    int n;
    t.push_back(row(1, 4,  32'h44444444, 4,  20, 4,  pk(32'h44444444, 0, 0, 0, 0, 0)));
    t.push_back(row(1, 20, 32'h20202020, 20, 4,  20, pk(32'h20202020, 32'h44444444, 0,
                                                      0, 32'h44444444, 0)));
    foreach (t[i]) begin
      drive(t[i].we, t[i].wa, t[i].wd, 1'b0, t[i].a1, t[i].a2, t[i].ad);
      sbq.push_back(mkexp($sformatf("mid_fill[%0d]", i), t[i].ev));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd20, 5'd20);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd20, 5'd20);
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    drive(1'b1, 5'd20, 32'h0BAD_0BAD, 1'b1, 5'd4, 5'd20, 5'd20);
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(mkexp($sformatf("mid_reset_out[%0d]", k), '0));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
      checks++;
      if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL mid_reset_busy got=%b exp=11", {busy_a, busy_b}); end
    end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd20, 5'd20);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (busy_a === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL mid_restart_len got=%0d exp=32", n); end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'((i + 16) % 32), 5'(31 - i));
      sbq.push_back(mkexp($sformatf("mid_sweep[%0d]", i), '0));
      step();
      e = sbq.pop_front();
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.v); end
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
